beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Recording/playback datapath that sits directly downstream of the mode FSM. Consumes `ram_load`, `keyboard_record` and `RD_load_from`, together with the live keyboard note. Stores one note per beat tick into an internal beat RAM while recording, and replays the stored loop at the same tick rate. Drives the single note code sent to the buzzer/tone generator.

## Interface
Parameters:
- `NOTE_W`, 4: width of a note code; 0 = silence.
- `ADDR_W`, 6: beat RAM address width; DEPTH = 2^ADDR_W slots.
- `TICK_DIV`, 12500000: clk cycles per beat (4 beats/s at 50 MHz); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ram_load`  in  1  from FSM; 1 = write beats into RAM.
- `keyboard_record`  in  1  from FSM; qualifies recording. Record only when both `ram_load` and this input are 1.
- `RD_load_from`  in  1  from FSM; 1 = live keyboard is the note source.
- `play_en`  in  1  playback request (SW[1] level).
- `key_note`  in  NOTE_W  current keyboard note code.
- `note_out`  out  NOTE_W  registered note to the buzzer.
- `beat_tick`  out  1  one-cycle pulse at each beat boundary.
- `beat_addr`  out  ADDR_W  current RAM slot.
- `rec_len`  out  ADDR_W+1  number of valid recorded beats, 0..DEPTH.
- `rec_full`  out  1  high while rec_len == DEPTH.

## Operation
- Divider `div` counts 0..TICK_DIV-1 and wraps. `beat_tick` = 1 in the cycle where div == TICK_DIV-1. `div` is cleared to 0 on every state entry, so the first beat of a take is a full period long.
- Memory: DEPTH×NOTE_W, synchronous write, registered read. Contents are not cleared by reset.
- States: IDLE, RECORD, PLAY.
- IDLE → RECORD when `ram_load & keyboard_record`. On entry, beat_addr = 0 and rec_len = 0 (the previous take is discarded).
- IDLE → PLAY when `play_en & !ram_load & rec_len != 0`. On entry, beat_addr = 0.
- Record has priority if both IDLE entry conditions hold.
- RECORD behaviour:
  - On each `beat_tick`: mem[beat_addr] ← key_note, beat_addr++, rec_len++.
  - → IDLE when `ram_load & keyboard_record` falls; rec_len is kept.
  - → IDLE when the write that makes rec_len == DEPTH occurs; beat_addr wraps to 0 and further beats are not written.
- PLAY behaviour:
  - On each `beat_tick`: read mem[beat_addr]. beat_addr increments, or wraps to 0 when beat_addr == rec_len-1 (loop).
  - → IDLE when `play_en` = 0 or `ram_load` = 1. A pending read is discarded.
- `note_out` source, registered every cycle:
  - RECORD: key_note.
  - PLAY: the playback register.
  - IDLE with RD_load_from = 1: key_note.
  - IDLE with RD_load_from = 0: 0.
- Playback register: loaded from RAM one cycle after each PLAY beat_tick. Cleared to 0 on PLAY entry.
- `rec_full` = (rec_len == DEPTH), combinational from the register.

## Timing
- Reset values:
  - state = IDLE; div, beat_addr, rec_len, and the playback register = 0.
  - note_out = 0, beat_tick = 0, rec_full = 0.
  - Reset mid-RECORD or mid-PLAY aborts immediately; the recorded take becomes unreachable (rec_len = 0).
- State change takes effect on the edge after the condition is seen; `div` is 0 in the first cycle of the new state.
- First RECORD write occurs TICK_DIV cycles after entry. It samples key_note during the tick cycle.
- Live path latency: key_note → note_out is 1 cycle.
- PLAY path latency: beat_tick → RAM read (edge 1) → playback register (edge 2) → note_out (edge 3). Slot k is audible from 3 cycles after its tick until 3 cycles after the next tick.
- Before the first PLAY tick, note_out = 0 for TICK_DIV+2 cycles.
- A falling record request in the same cycle as beat_tick still commits that beat's write.

## Test plan
Run with TICK_DIV=4, ADDR_W=3.
- Reset mid-PLAY → next cycle note_out=0, rec_len=0, beat_addr=0. A later play_en=1 stays in IDLE.
- Record 3 beats: hold ram_load=keyboard_record=1 with key_note 5,9,2 on successive ticks, then drop. → rec_len=3; mem[0..2]=5,9,2; note_out tracks key_note with 1-cycle lag.
- Play with play_en=1 → note_out sequence 5,9,2,5,9,… each held 4 cycles, first change 3 cycles after the first tick. beat_addr wraps 2→0.
- Record 10 beats into DEPTH=8 → rec_full=1 after the 8th write, state IDLE, beat_addr=0, mem[7] = 8th note. Beats 9–10 are not written.
- play_en=1 and ram_load=keyboard_record=1 asserted in the same cycle from IDLE → RECORD entered, rec_len reset to 0.
- play_en=1 with rec_len=0, RD_load_from=0 → stays IDLE, note_out=0. With RD_load_from=1 and key_note=7 → note_out=7 after 1 cycle.

Source files
------------

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
// Records one keyboard note per beat into an internal beat RAM and plays the
// stored loop back at the same beat rate. It also selects the single note code
// that is sent to the buzzer.
//
// Ports
//   clk             system clock; all state changes on its rising edge
//   reset           asynchronous, active-high reset
//   ram_load        1 = write beats into RAM (from the mode FSM)
//   keyboard_record qualifies recording together with ram_load
//   RD_load_from    1 = live keyboard drives the buzzer while idle
//   play_en         playback request (level)
//   key_note        current keyboard note code (0 = silence)
//   note_out        registered note code to the buzzer
//   beat_tick       one-cycle pulse at every beat boundary
//   beat_addr       current beat RAM slot
//   rec_len         number of valid recorded beats, 0..DEPTH
//   rec_full        high while rec_len == DEPTH
// -----------------------------------------------------------------------------
module beat_sequencer #(
    parameter int NOTE_W   = 4,
    parameter int ADDR_W   = 6,
    parameter int TICK_DIV = 12500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_load,
    input  logic              keyboard_record,
    input  logic              RD_load_from,
    input  logic              play_en,
    input  logic [NOTE_W-1:0] key_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              beat_tick,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [ADDR_W:0]   rec_len,
    output logic              rec_full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_PLAY
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [NOTE_W-1:0]   play_q, play_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                rd_valid_q, rd_valid_d;

    // Beat RAM: synchronous write, registered read, never cleared.
    logic [NOTE_W-1:0]   mem [DEPTH];
    logic [NOTE_W-1:0]   rd_data_q;
    logic                mem_we;
    logic                mem_re;

    logic                tick;
    logic                rec_req;

    assign tick    = (div_q == DIV_LAST);
    assign rec_req = ram_load & keyboard_record;

    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        addr_d     = addr_q;
        len_d      = len_q;
        play_d     = play_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Recording wins when both entry conditions hold.
                if (rec_req) begin
                    state_d = S_RECORD;
                    div_d   = '0;
                    addr_d  = '0;
                    len_d   = '0;
                end else if (play_en && !ram_load && (len_q != '0)) begin
                    state_d = S_PLAY;
                    div_d   = '0;
                    addr_d  = '0;
                    play_d  = '0;
                end
            end

            S_RECORD: begin
                // A tick in the same cycle as a dropped request still commits.
                if (tick) begin
                    mem_we = 1'b1;
                    if (len_q == DEPTH_L - 1'b1) begin
                        len_d   = DEPTH_L;
                        addr_d  = '0;
                        state_d = S_IDLE;
                        div_d   = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        len_d  = len_q + 1'b1;
                    end
                end
                if (!rec_req) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end
            end

            S_PLAY: begin
                if (!play_en || ram_load) begin
                    // Leaving drops any read still in flight.
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    if (rd_valid_q) begin
                        play_d = rd_data_q;
                    end
                    if (tick) begin
                        mem_re     = 1'b1;
                        rd_valid_d = 1'b1;
                        // Loop back to slot 0 after the last recorded beat.
                        addr_d = ({1'b0, addr_q} == len_q - 1'b1) ? '0 : addr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase

        case (state_q)
            S_RECORD: note_d = key_note;
            S_PLAY:   note_d = play_q;
            default:  note_d = RD_load_from ? key_note : '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            play_q     <= '0;
            note_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            play_q     <= play_d;
            note_q     <= note_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= key_note;
        end
        if (mem_re) begin
            rd_data_q <= mem[addr_q];
        end
    end

    assign note_out  = note_q;
    assign beat_tick = tick;
    assign beat_addr = addr_q;
    assign rec_len   = len_q;
    assign rec_full  = (len_q == DEPTH_L);

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
// Directed sequence of record/play/reset scenarios with random note values,
// checked against a simple model: an array of recorded notes plus arithmetic
// on the cycle count since the start of each take or playback.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

    localparam int NW    = 4;
    localparam int AW    = 3;
    localparam int TD    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int FILL  = TD + 2;   // cycles of silence before the first played note

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_load;
    logic          keyboard_record;
    logic          RD_load_from;
    logic          play_en;
    logic [NW-1:0] key_note;
    logic [NW-1:0] note_out;
    logic          beat_tick;
    logic [AW-1:0] beat_addr;
    logic [AW:0]   rec_len;
    logic          rec_full;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NW-1:0] model_mem [DEPTH];
    int            model_len = 0;

    beat_sequencer #(
        .NOTE_W  (NW),
        .ADDR_W  (AW),
        .TICK_DIV(TD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ram_load       (ram_load),
        .keyboard_record(keyboard_record),
        .RD_load_from   (RD_load_from),
        .play_en        (play_en),
        .key_note       (key_note),
        .note_out       (note_out),
        .beat_tick      (beat_tick),
        .beat_addr      (beat_addr),
        .rec_len        (rec_len),
        .rec_full       (rec_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // play_en held with an empty take must not start playback; the live
    // keyboard path is then exercised through RD_load_from.
    task automatic idle_checks();
        logic [NW-1:0] prev;
        play_en      = 1'b1;
        RD_load_from = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle_addr", 32'(beat_addr), 32'd0);
            check("idle_note", 32'(note_out), 32'd0);
            check("idle_len", 32'(rec_len), 32'd0);
        end
        RD_load_from = 1'b1;
        key_note     = 4'd7;
        prev         = key_note;
        for (int i = 0; i < 5; i++) begin
            step();
            check("live_note", 32'(note_out), 32'(prev));
            key_note = NW'($urandom_range(0, 15));
            prev     = key_note;
        end
        RD_load_from = 1'b0;
        play_en      = 1'b0;
        step();
        step();
        $display("idle check: play_en with empty take, live path done");
    endtask

    task automatic do_record(input int n, input bit with_play);
        logic [NW-1:0] prev;
        int            beats;
        ram_load        = 1'b1;
        keyboard_record = 1'b1;
        play_en         = with_play;
        key_note        = NW'($urandom_range(1, 15));
        prev            = key_note;
        for (int c = 0; c < 4 * DEPTH + 8; c++) begin
            step();
            check("rec_len", 32'(rec_len), 32'(c / TD));
            check("rec_addr", 32'(beat_addr), 32'(c / TD));
            check("rec_tick", 32'(beat_tick), 32'((c % TD) == TD - 1));
            check("rec_full_lo", 32'(rec_full), 32'd0);
            check("rec_note", 32'(note_out), (c == 0) ? 32'd0 : 32'(prev));
            key_note = NW'($urandom_range(1, 15));
            prev     = key_note;
            if ((c % TD) == TD - 1) begin
                model_mem[c / TD] = key_note;
                beats = c / TD + 1;
                if (beats == n) begin
                    if (n < DEPTH) begin
                        ram_load        = 1'b0;
                        keyboard_record = 1'b0;
                        play_en         = 1'b0;
                    end
                    break;
                end
            end
        end
        step();
        check("rec_end_note", 32'(note_out), 32'(prev));
        check("rec_end_len", 32'(rec_len), 32'(n));
        check("rec_end_full", 32'(rec_full), 32'(n == DEPTH));
        check("rec_end_addr", 32'(beat_addr), (n == DEPTH) ? 32'd0 : 32'(n));
        ram_load        = 1'b0;
        keyboard_record = 1'b0;
        play_en         = 1'b0;
        step();
        step();
        check("rec_kept_len", 32'(rec_len), 32'(n));
        check("rec_kept_full", 32'(rec_full), 32'(n == DEPTH));
        check("rec_idle_note", 32'(note_out), 32'd0);
        model_len = n;
        $display("record take: %0d beats, play_en=%0d", n, with_play);
    endtask

    task automatic do_play(input int ncycles, input bit reset_at_end);
        logic [NW-1:0] exp_note;
        play_en = 1'b1;
        for (int c = 0; c < ncycles; c++) begin
            step();
            check("play_addr", 32'(beat_addr), 32'((c / TD) % model_len));
            check("play_tick", 32'(beat_tick), 32'((c % TD) == TD - 1));
            exp_note = (c >= FILL) ? model_mem[((c - FILL) / TD) % model_len] : '0;
            check("play_note", 32'(note_out), 32'(exp_note));
        end
        if (reset_at_end) begin
            reset = 1'b1;
            #1;
            check("rst_note", 32'(note_out), 32'd0);
            check("rst_len", 32'(rec_len), 32'd0);
            check("rst_addr", 32'(beat_addr), 32'd0);
            check("rst_full", 32'(rec_full), 32'd0);
            check("rst_tick", 32'(beat_tick), 32'd0);
            @(posedge clk);
            #1;
            reset     = 1'b0;
            model_len = 0;
            $display("play: %0d cycles then reset", ncycles);
            idle_checks();
        end else begin
            play_en = 1'b0;
            step();
            step();
            step();
            check("play_exit_note", 32'(note_out), 32'd0);
            check("play_exit_len", 32'(rec_len), 32'(model_len));
            $display("play: %0d cycles over %0d-beat loop", ncycles, model_len);
        end
    endtask

    initial begin
        reset           = 1'b1;
        ram_load        = 1'b0;
        keyboard_record = 1'b0;
        RD_load_from    = 1'b0;
        play_en         = 1'b0;
        key_note        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_note", 32'(note_out), 32'd0);
        check("reset_tick", 32'(beat_tick), 32'd0);
        check("reset_full", 32'(rec_full), 32'd0);
        check("reset_len", 32'(rec_len), 32'd0);
        check("reset_addr", 32'(beat_addr), 32'd0);
        reset = 1'b0;
        step();

        idle_checks();
        do_record(3, 1'b0);
        do_play(30, 1'b0);
        do_play(9, 1'b1);
        do_record(4, 1'b0);
        do_record(DEPTH, 1'b1);
        do_play(4 * DEPTH + FILL + 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
